conv_mask_wt_sched: RTL and testbench

//   Configuration/sequencing controller for the conv_mask6/5/4 filter bank.

---
 rtl/conv_mask_wt_sched.sv | 119 +++++++++++
 tb/tb_conv_mask_wt_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mask_wt_sched.sv
// Weight-table and dataEn sequencer for the conv_mask6/5/4 bank.
// Weights are written to a shadow table and promoted to the active table only between frames.
module conv_mask_wt_sched #(
    parameter int NUM_W    = 29,
    parameter int AW       = 5,
    parameter int PIPE_LAT = 6
) (
    input  logic                  isp_clk,
    input  logic                  rst,
    input  logic                  cfg_wr_en,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [15:0]           cfg_wdata,
    input  logic                  cfg_commit,
    input  logic                  frame_start,
    input  logic                  frame_end,
    input  logic                  pix_valid,
    output logic [16*NUM_W-1:0]   wt_active,
    output logic                  wt_valid,
    output logic                  data_en,
    output logic                  commit_pend,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err
);

    localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   drain_cnt;
    logic [CW-1:0]   drain_cnt_nxt;
    logic [15:0]     shadow [NUM_W];
    logic [15:0]     active [NUM_W];
    logic            swap;
    logic            addr_ok;
    logic            start_err;

    assign busy    = (state == RUN) || (state == DRAIN);
    assign swap    = commit_pend && !busy;
    assign addr_ok = 32'(cfg_addr) < 32'(NUM_W);

    for (genvar g = 0; g < NUM_W; g++) begin : g_pack
        assign wt_active[16*g +: 16] = active[g];
    end

    // A frame_start colliding with frame_end in RUN is absorbed by the frame_end.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        start_err     = 1'b0;
        data_en       = 1'b0;
        case (state)
            IDLE: begin
                start_err = frame_start;
                if (swap) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (frame_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                data_en = pix_valid;
                if (frame_end) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = CW'(PIPE_LAT - 1);
                end else begin
                    start_err = frame_start;
                end
            end
            DRAIN: begin
                data_en   = 1'b1;
                start_err = frame_start;
                if (drain_cnt == '0) begin
                    state_nxt = ARMED;
                end else begin
                    drain_cnt_nxt = drain_cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Swap reads the shadow as it stood before this cycle's write, so a coincident write waits for the next commit.
    always_ff @(posedge isp_clk) begin
        if (rst) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            commit_pend <= 1'b0;
            wt_valid    <= 1'b0;
            frame_done  <= 1'b0;
            cfg_err     <= 1'b0;
            for (int i = 0; i < NUM_W; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_cnt_nxt;
            commit_pend <= cfg_commit || (commit_pend && !swap);
            frame_done  <= (state == DRAIN) && (drain_cnt == '0);
            cfg_err     <= (cfg_wr_en && !addr_ok) || start_err;
            if (swap) begin
                wt_valid <= 1'b1;
                for (int i = 0; i < NUM_W; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (cfg_wr_en && addr_ok) begin
                shadow[cfg_addr] <= cfg_wdata;
            end
        end
    end

endmodule

// File: tb/tb_conv_mask_wt_sched.sv
// Scoreboard bench for conv_mask_wt_sched: a frame-level reference model predicts every
// cycle's outputs, a negedge monitor compares them, plus a few directed constant checks.
module tb_conv_mask_wt_sched;

    localparam int NUM_W    = 29;
    localparam int AW       = 5;
    localparam int PIPE_LAT = 6;
    localparam int W        = 16 * NUM_W;

    logic           isp_clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_wr_en = 1'b0;
    logic [AW-1:0]  cfg_addr = '0;
    logic [15:0]    cfg_wdata = '0;
    logic           cfg_commit = 1'b0;
    logic           frame_start = 1'b0;
    logic           frame_end = 1'b0;
    logic           pix_valid = 1'b0;
    logic [W-1:0]   wt_active;
    logic           wt_valid;
    logic           data_en;
    logic           commit_pend;
    logic           busy;
    logic           frame_done;
    logic           cfg_err;

    conv_mask_wt_sched #(.NUM_W(NUM_W), .AW(AW), .PIPE_LAT(PIPE_LAT)) dut (
        .isp_clk     (isp_clk),
        .rst         (rst),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .pix_valid   (pix_valid),
        .wt_active   (wt_active),
        .wt_valid    (wt_valid),
        .data_en     (data_en),
        .commit_pend (commit_pend),
        .busy        (busy),
        .frame_done  (frame_done),
        .cfg_err     (cfg_err)
    );

    always #5 isp_clk = ~isp_clk;

    typedef struct {
        logic [W-1:0] wt_active;
        logic         wt_valid;
        logic         data_en;
        logic         commit_pend;
        logic         busy;
        logic         frame_done;
        logic         cfg_err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: weights as arrays, frame progress as "in frame" plus cycles of drain left.
    bit          m_known = 0;
    logic [15:0] m_shadow [NUM_W];
    logic [15:0] m_active [NUM_W];
    bit          m_valid, m_pend, m_run, m_done, m_err;
    int          m_drain_left;

    function automatic exp_t modelOutputs(input logic pv);
        exp_t e;
        for (int i = 0; i < NUM_W; i++) e.wt_active[16*i +: 16] = m_active[i];
        e.wt_valid    = m_valid;
        e.commit_pend = m_pend;
        e.busy        = m_run || (m_drain_left > 0);
        e.frame_done  = m_done;
        e.cfg_err     = m_err;
        e.data_en     = m_run ? pv : (m_drain_left > 0);
        return e;
    endfunction

    task automatic modelStep(input logic r, input logic wr, input int a, input logic [15:0] d,
                             input logic c, input logic fs, input logic fe);
        bit between_frames, swap, armed, done;
        if (r) begin
            for (int i = 0; i < NUM_W; i++) begin
                m_shadow[i] = '0;
                m_active[i] = '0;
            end
            m_valid = 0; m_pend = 0; m_run = 0; m_done = 0; m_err = 0;
            m_drain_left = 0;
            m_known = 1;
            return;
        end
        between_frames = !m_run && (m_drain_left == 0);
        swap  = m_pend && between_frames;
        armed = m_valid && between_frames;
        m_err = (wr && a >= NUM_W) || (fs && !armed && !(m_run && fe));
        if (swap) m_active = m_shadow;
        if (wr && a < NUM_W) m_shadow[a] = d;
        m_pend = c || (m_pend && !swap);
        if (swap) m_valid = 1;
        done = 0;
        if (m_run) begin
            if (fe) begin
                m_run = 0;
                m_drain_left = PIPE_LAT;
            end
        end else if (m_drain_left > 0) begin
            m_drain_left--;
            done = (m_drain_left == 0);
        end else if (armed && fs) begin
            m_run = 1;
        end
        m_done = done;
    endtask

    task automatic applyStimulus(input logic r, input logic wr, input int a, input logic [15:0] d,
                                 input logic c, input logic fs, input logic fe, input logic pv);
        @(posedge isp_clk);
        #1;
        rst         = r;
        cfg_wr_en   = wr;
        cfg_addr    = AW'(a);
        cfg_wdata   = d;
        cfg_commit  = c;
        frame_start = fs;
        frame_end   = fe;
        pix_valid   = pv;
        if (m_known) exp_q.push_back(modelOutputs(pv));
        modelStep(r, wr, a, d, c, fs, fe);
    endtask

    task automatic idle(input logic pv);
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 0, pv);
    endtask

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        cmp("wt_active",   wt_active,      e.wt_active);
        cmp("wt_valid",    W'(wt_valid),    W'(e.wt_valid));
        cmp("data_en",     W'(data_en),     W'(e.data_en));
        cmp("commit_pend", W'(commit_pend), W'(e.commit_pend));
        cmp("busy",        W'(busy),        W'(e.busy));
        cmp("frame_done",  W'(frame_done),  W'(e.frame_done));
        cmp("cfg_err",     W'(cfg_err),     W'(e.cfg_err));
    endtask

    always @(negedge isp_clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    task automatic atNeg();
        @(negedge isp_clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset, then load entry 0 and commit from IDLE.
        applyStimulus(1, 0, 0, 16'h0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 16'h0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 16'hFFF0, 1, 0, 0, 0);
        atNeg();
        cmp("reset wt_active", wt_active, '0);
        cmp("reset wt_valid", W'(wt_valid), '0);
        cmp("reset busy", W'(busy), '0);
        idle(0);
        idle(0);
        atNeg();
        cmp("t1 entry0", W'(wt_active[15:0]), W'(16'hFFF0));
        cmp("t1 wt_valid", W'(wt_valid), W'(1'b1));

        // Plain frame followed by the drain window.
        applyStimulus(0, 0, 0, 16'h0, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++) idle(logic'($urandom_range(0, 1)));
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 1, 1);
        for (int k = 1; k <= 8; k++) begin
            idle(1);
            atNeg();
            cmp($sformatf("t2 drain data_en %0d", k), W'(data_en), W'(k <= PIPE_LAT));
            cmp($sformatf("t2 frame_done %0d", k), W'(frame_done), W'(k == PIPE_LAT + 1));
        end

        // Commit during RUN is held until the frame has drained.
        applyStimulus(0, 0, 0, 16'h0, 0, 1, 0, 1);
        applyStimulus(0, 1, 9, 16'h0010, 1, 0, 0, 1);
        idle(0);
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 1, 1);
        for (int k = 1; k <= 8; k++) begin
            idle(0);
            atNeg();
            cmp($sformatf("t3 entry9 %0d", k), W'(wt_active[16*9 +: 16]),
                W'((k >= PIPE_LAT + 2) ? 16'h0010 : 16'h0000));
            cmp($sformatf("t3 commit_pend %0d", k), W'(commit_pend), W'(k <= PIPE_LAT + 1));
        end

        // Out-of-range write, then frame_start while still IDLE.
        applyStimulus(0, 1, 30, 16'hBEEF, 0, 0, 0, 0);
        idle(0);
        atNeg();
        cmp("t4 addr err", W'(cfg_err), W'(1'b1));
        applyStimulus(1, 0, 0, 16'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 16'h0, 0, 1, 0, 1);
        idle(1);
        atNeg();
        cmp("t4 idle start err", W'(cfg_err), W'(1'b1));
        cmp("t4 idle data_en", W'(data_en), '0);

        // Reset in the middle of the drain window.
        applyStimulus(0, 1, 3, 16'h7FFF, 1, 0, 0, 0);
        idle(0);
        idle(0);
        applyStimulus(0, 0, 0, 16'h0, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) idle(1);
        applyStimulus(0, 0, 0, 16'h0, 0, 0, 1, 1);
        idle(1);
        idle(1);
        applyStimulus(1, 0, 0, 16'h0, 0, 0, 0, 1);
        idle(1);
        atNeg();
        cmp("t5 data_en", W'(data_en), '0);
        cmp("t5 busy", W'(busy), '0);
        cmp("t5 wt_valid", W'(wt_valid), '0);
        cmp("t5 wt_active", wt_active, '0);

        // Swap coinciding with frame_start: the frame must see the new weights.
        applyStimulus(0, 1, 0, 16'h0001, 1, 0, 0, 0);
        idle(0);
        idle(0);
        applyStimulus(0, 1, 5, 16'h1234, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 16'h0, 0, 1, 0, 1);
        idle(1);
        atNeg();
        cmp("t6 busy", W'(busy), W'(1'b1));
        cmp("t6 entry5", W'(wt_active[16*5 +: 16]), W'(16'h1234));
        applyStimulus(0, 1, 28, 16'h8000, 1, 1, 1, 1);
        for (int k = 0; k < PIPE_LAT + 3; k++) idle(0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 499) == 0),
                          ($urandom_range(0, 9) < 3),
                          int'($urandom_range(0, 31)),
                          16'($urandom),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 9) < 7));
        end
        idle(0);
        atNeg();
        atNeg();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
